// File: rtl/ft232h_avalon_sys_rst_ctrl.sv
// -----------------------------------------------------------------------------
// ft232h_avalon_sys_rst_ctrl
//
// PLL reset sequencer and lock monitor for the FT232H Avalon system. Runs on
// the free-running 24 MHz reference clock. It pulses the PLL reset, waits for
// a stable lock, then releases the Avalon fabric reset and, a few cycles
// later, the FT232H core reset. A lock drop while running forces both resets
// back on, sets a sticky flag and counts the event.
//
// Build option:
//   FT232H_RST_CTRL_RELOCK_EN  defined   -> lock loss and lock timeout both
//                                           re-pulse the PLL reset; timeouts
//                                           are counted as recovery attempts.
//                              undefined -> the PLL reset is pulsed only after
//                                           i_rst; lock loss waits for relock,
//                                           timeouts are ignored.
//
// Ports:
//   i_refclk          24 MHz reference clock (only clock)
//   i_rst             asynchronous active-high reset
//   i_pll_locked      PLL locked, asynchronous to i_refclk
//   i_lock_lost_clr   one-cycle pulse clearing o_lock_lost
//   o_pll_rst         reset to the PLL
//   o_sys_reset       active-high reset for the 96 MHz Avalon fabric
//   o_core_reset      active-high reset for the FT232H core
//   o_lock_lost       sticky: lock dropped while in RUN
//   o_relock_count    saturating count of recovery attempts
//   o_state           0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module ft232h_avalon_sys_rst_ctrl #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 2400,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 24000,
  parameter int unsigned RELEASE_GAP_CYCLES  = 24,
  parameter int unsigned CNT_W               = 16
) (
  input  logic       i_refclk,
  input  logic       i_rst,
  input  logic       i_pll_locked,
  input  logic       i_lock_lost_clr,
  output logic       o_pll_rst,
  output logic       o_sys_reset,
  output logic       o_core_reset,
  output logic       o_lock_lost,
  output logic [7:0] o_relock_count,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    StPllRst   = 2'd0,
    StWaitLock = 2'd1,
    StStable   = 2'd2,
    StRun      = 2'd3
  } state_t;

  // Terminal counter values; a zero-length gap is clamped so it cannot underflow.
  localparam logic [CNT_W-1:0] C_PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST     =
      (RELEASE_GAP_CYCLES == 0) ? '0 : CNT_W'(RELEASE_GAP_CYCLES - 1);
  localparam logic             C_CORE_AT_RUN  = (RELEASE_GAP_CYCLES != 0);
  localparam logic [CNT_W-1:0] C_ONE          = CNT_W'(1);

  // Registers
  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pll_rst;
  logic             r_sys_reset;
  logic             r_core_reset;
  logic             r_lock_lost;
  logic [7:0]       r_relock_count;

  // Next-state wires
  logic             w_lk;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_sys_reset_nxt;
  logic             w_core_reset_nxt;
  logic             w_lost_set;
  logic             w_relock_inc;
  logic             w_lock_lost_nxt;
  logic [7:0]       w_relock_count_nxt;

  // 2-FF synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge i_refclk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lk = r_sync2;

  // Sequencer next-state logic. One counter is shared by every state and is
  // cleared on each state change.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_sys_reset_nxt  = 1'b1;
    w_core_reset_nxt = 1'b1;
    w_lost_set       = 1'b0;
    w_relock_inc     = 1'b0;

    case (r_state)
      StPllRst: begin
        if (r_cnt == C_PLL_LAST) begin
          w_state_nxt = StWaitLock;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end

      StWaitLock: begin
        if (w_lk) begin
          w_state_nxt = StStable;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_TIMEOUT_LAST) begin
`ifdef FT232H_RST_CTRL_RELOCK_EN
          w_relock_inc = 1'b1;
          w_state_nxt  = StPllRst;
          w_cnt_nxt    = '0;
`else
          // No recovery path: park the counter and keep waiting for lock.
          w_cnt_nxt = r_cnt;
`endif
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end

      StStable: begin
        if (!w_lk) begin
          // Lock bounced before it was trusted: not a lock loss, just restart.
          w_state_nxt = StWaitLock;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_STABLE_LAST) begin
          w_state_nxt      = StRun;
          w_cnt_nxt        = '0;
          w_sys_reset_nxt  = 1'b0;
          w_core_reset_nxt = C_CORE_AT_RUN;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end

      StRun: begin
        if (!w_lk) begin
          w_lost_set   = 1'b1;
          w_relock_inc = 1'b1;
          w_cnt_nxt    = '0;
`ifdef FT232H_RST_CTRL_RELOCK_EN
          w_state_nxt  = StPllRst;
`else
          w_state_nxt  = StWaitLock;
`endif
        end else begin
          w_sys_reset_nxt  = 1'b0;
          w_core_reset_nxt = r_core_reset;
          // Counter measures the sys->core release gap, then holds.
          if (r_cnt == C_GAP_LAST) begin
            w_core_reset_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end
      end

      default: begin
        w_state_nxt = StPllRst;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Set has priority over the software clear.
  assign w_lock_lost_nxt    = w_lost_set | (r_lock_lost & ~i_lock_lost_clr);
  assign w_relock_count_nxt = (w_relock_inc && (r_relock_count != 8'hFF)) ?
                              r_relock_count + 8'd1 : r_relock_count;

  always_ff @(posedge i_refclk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= StPllRst;
      r_cnt          <= '0;
      r_pll_rst      <= 1'b1;
      r_sys_reset    <= 1'b1;
      r_core_reset   <= 1'b1;
      r_lock_lost    <= 1'b0;
      r_relock_count <= 8'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      // Registered from the next state so pll_rst tracks PLL_RST exactly.
      r_pll_rst      <= (w_state_nxt == StPllRst);
      r_sys_reset    <= w_sys_reset_nxt;
      r_core_reset   <= w_core_reset_nxt;
      r_lock_lost    <= w_lock_lost_nxt;
      r_relock_count <= w_relock_count_nxt;
    end
  end

  assign o_pll_rst      = r_pll_rst;
  assign o_sys_reset    = r_sys_reset;
  assign o_core_reset   = r_core_reset;
  assign o_lock_lost    = r_lock_lost;
  assign o_relock_count = r_relock_count;
  assign o_state        = r_state;

endmodule

// File: tb/tb_ft232h_avalon_sys_rst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ft232h_avalon_sys_rst_ctrl
//
// Directed bench for the PLL reset sequencer with small cycle parameters.
// Edge numbers in comments count refclk rising edges after i_rst is released.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
// Expected values follow FT232H_RST_CTRL_RELOCK_EN if it is defined.
// -----------------------------------------------------------------------------
module tb_ft232h_avalon_sys_rst_ctrl;

`ifdef FT232H_RST_CTRL_RELOCK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       lock_lost_clr = 1'b0;
  logic       pll_rst;
  logic       sys_reset;
  logic       core_reset;
  logic       lock_lost;
  logic [7:0] relock_count;
  logic [1:0] state;

  int chk = 0;
  int fails = 0;
  logic [13:0] obs;
  logic [13:0] e;

  assign obs = {pll_rst, sys_reset, core_reset, lock_lost, relock_count, state};

  ft232h_avalon_sys_rst_ctrl #(
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .RELEASE_GAP_CYCLES (3),
    .CNT_W              (16)
  ) dut (
    .i_refclk       (clk),
    .i_rst          (rst),
    .i_pll_locked   (pll_locked),
    .i_lock_lost_clr(lock_lost_clr),
    .o_pll_rst      (pll_rst),
    .o_sys_reset    (sys_reset),
    .o_core_reset   (core_reset),
    .o_lock_lost    (lock_lost),
    .o_relock_count (relock_count),
    .o_state        (state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] vec(input logic p, input logic s, input logic c,
                                      input logic l, input logic [7:0] n,
                                      input logic [1:0] st);
    return {p, s, c, l, n, st};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, release 1 unit after an edge with the given lock level.
  task automatic apply_reset(input logic lock);
    rst = 1'b1;
    pll_locked = 1'b0;
    lock_lost_clr = 1'b0;
    tick(2);
    rst = 1'b0;
    pll_locked = lock;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    tick(2);
    e = vec(1, 1, 1, 0, 8'd0, 2'd0);
    chk++; if (obs !== e) begin fails++; $display("FAIL reset_vals: got %h want %h", obs, e); end
  endtask

  task automatic test_bringup;
    rst = 1'b0;
    tick(3);
    e = vec(1, 1, 1, 0, 8'd0, 2'd0);
    chk++; if (obs !== e) begin fails++; $display("FAIL bringup_pllrst_hi: got %h want %h", obs, e); end
    tick(1);
    e = vec(0, 1, 1, 0, 8'd0, 2'd1);
    chk++; if (obs !== e) begin fails++; $display("FAIL bringup_pllrst_lo: got %h want %h", obs, e); end
    tick(6);
    pll_locked = 1'b1;                 // first sampled at edge 11
    tick(10);                          // edge 20: still STABLE
    e = vec(0, 1, 1, 0, 8'd0, 2'd2);
    chk++; if (obs !== e) begin fails++; $display("FAIL bringup_stable: got %h want %h", obs, e); end
    tick(1);                           // edge 21: sys released
    e = vec(0, 0, 1, 0, 8'd0, 2'd3);
    chk++; if (obs !== e) begin fails++; $display("FAIL bringup_sys_rel: got %h want %h", obs, e); end
    tick(2);
    chk++; if (obs !== e) begin fails++; $display("FAIL bringup_gap: got %h want %h", obs, e); end
    tick(1);                           // edge 24: core released
    e = vec(0, 0, 0, 0, 8'd0, 2'd3);
    chk++; if (obs !== e) begin fails++; $display("FAIL bringup_core_rel: got %h want %h", obs, e); end
  endtask

  task automatic test_unstable;
    apply_reset(1'b1);                 // lk at edge 2, STABLE at edge 5
    tick(9);
    pll_locked = 1'b0;                 // during 5th STABLE cycle
    tick(2);
    pll_locked = 1'b1;
    tick(1);                           // edge 12: back to WAIT_LOCK
    e = vec(0, 1, 1, 0, 8'd0, 2'd1);
    chk++; if (obs !== e) begin fails++; $display("FAIL unstable_back: got %h want %h", obs, e); end
    tick(9);                           // edge 21: STABLE since 14, 7 cycles in
    e = vec(0, 1, 1, 0, 8'd0, 2'd2);
    chk++; if (obs !== e) begin fails++; $display("FAIL unstable_recount: got %h want %h", obs, e); end
    tick(1);                           // edge 22: RUN
    e = vec(0, 0, 1, 0, 8'd0, 2'd3);
    chk++; if (obs !== e) begin fails++; $display("FAIL unstable_run: got %h want %h", obs, e); end
  endtask

  task automatic test_lock_loss;
    tick(3);                           // edge 25: core released
    e = vec(0, 0, 0, 0, 8'd0, 2'd3);
    chk++; if (obs !== e) begin fails++; $display("FAIL loss_pre: got %h want %h", obs, e); end
    pll_locked = 1'b0;
    tick(2);
    chk++; if (obs !== e) begin fails++; $display("FAIL loss_sync_delay: got %h want %h", obs, e); end
    tick(1);                           // edge 28: resets back on
    e = vec(EN, 1, 1, 1, 8'd1, EN ? 2'd0 : 2'd1);
    chk++; if (obs !== e) begin fails++; $display("FAIL loss_hit: got %h want %h", obs, e); end
    tick(3);
    chk++; if (obs !== e) begin fails++; $display("FAIL loss_pll_pulse: got %h want %h", obs, e); end
    tick(1);                           // edge 32
    e = vec(0, 1, 1, 1, 8'd1, 2'd1);
    chk++; if (obs !== e) begin fails++; $display("FAIL loss_pll_end: got %h want %h", obs, e); end
    pll_locked = 1'b1;
    tick(10);
    e = vec(0, 1, 1, 1, 8'd1, 2'd2);
    chk++; if (obs !== e) begin fails++; $display("FAIL loss_relock_stable: got %h want %h", obs, e); end
    tick(1);
    e = vec(0, 0, 1, 1, 8'd1, 2'd3);
    chk++; if (obs !== e) begin fails++; $display("FAIL loss_relock_run: got %h want %h", obs, e); end
    tick(3);
    e = vec(0, 0, 0, 1, 8'd1, 2'd3);
    chk++; if (obs !== e) begin fails++; $display("FAIL loss_relock_core: got %h want %h", obs, e); end
    lock_lost_clr = 1'b1;
    tick(1);
    lock_lost_clr = 1'b0;
    e = vec(0, 0, 0, 0, 8'd1, 2'd3);
    chk++; if (obs !== e) begin fails++; $display("FAIL loss_clr: got %h want %h", obs, e); end
  endtask

  task automatic test_timeout;
    apply_reset(1'b0);
    tick(35);                          // last WAIT_LOCK cycle before timeout
    e = vec(0, 1, 1, 0, 8'd0, 2'd1);
    chk++; if (obs !== e) begin fails++; $display("FAIL timeout_pre: got %h want %h", obs, e); end
    tick(1);                           // edge 36: first timeout
    e = vec(EN, 1, 1, 0, EN ? 8'd1 : 8'd0, EN ? 2'd0 : 2'd1);
    chk++; if (obs !== e) begin fails++; $display("FAIL timeout_first: got %h want %h", obs, e); end
    tick(3);
    chk++; if (obs !== e) begin fails++; $display("FAIL timeout_pulse: got %h want %h", obs, e); end
    tick(1);                           // edge 40
    e = vec(0, 1, 1, 0, EN ? 8'd1 : 8'd0, 2'd1);
    chk++; if (obs !== e) begin fails++; $display("FAIL timeout_pulse_end: got %h want %h", obs, e); end
    tick(31);
    chk++; if (obs !== e) begin fails++; $display("FAIL timeout_wait2: got %h want %h", obs, e); end
    tick(1);                           // edge 72: second timeout
    e = vec(EN, 1, 1, 0, EN ? 8'd2 : 8'd0, EN ? 2'd0 : 2'd1);
    chk++; if (obs !== e) begin fails++; $display("FAIL timeout_second: got %h want %h", obs, e); end
    tick(9179 - 72);
    e = vec(0, 1, 1, 0, EN ? 8'd254 : 8'd0, 2'd1);
    chk++; if (obs !== e) begin fails++; $display("FAIL timeout_254: got %h want %h", obs, e); end
    tick(1);                           // edge 9180: 255th timeout
    e = vec(EN, 1, 1, 0, EN ? 8'd255 : 8'd0, EN ? 2'd0 : 2'd1);
    chk++; if (obs !== e) begin fails++; $display("FAIL timeout_255: got %h want %h", obs, e); end
    tick(10800 - 9180);                // edge 10800: 300th timeout
    chk++; if (obs !== e) begin fails++; $display("FAIL timeout_saturate: got %h want %h", obs, e); end
  endtask

  task automatic test_set_wins;
    apply_reset(1'b1);
    tick(16);                          // RUN since 13, core released at 16
    e = vec(0, 0, 0, 0, 8'd0, 2'd3);
    chk++; if (obs !== e) begin fails++; $display("FAIL setwins_run: got %h want %h", obs, e); end
    pll_locked = 1'b0;                 // loss detected at edge 19
    tick(2);
    lock_lost_clr = 1'b1;
    tick(1);
    lock_lost_clr = 1'b0;
    e = vec(EN, 1, 1, 1, 8'd1, EN ? 2'd0 : 2'd1);
    chk++; if (obs !== e) begin fails++; $display("FAIL setwins_flag: got %h want %h", obs, e); end
    tick(2);                           // mid-count in PLL_RST / WAIT_LOCK
    #2 rst = 1'b1;
    #1;
    e = vec(1, 1, 1, 0, 8'd0, 2'd0);
    chk++; if (obs !== e) begin fails++; $display("FAIL setwins_async_rst: got %h want %h", obs, e); end
  endtask

  task automatic test_mid_reset;
    apply_reset(1'b1);
    tick(16);
    e = vec(0, 0, 0, 0, 8'd0, 2'd3);
    chk++; if (obs !== e) begin fails++; $display("FAIL midrst_run: got %h want %h", obs, e); end
    #2 rst = 1'b1;                     // between edges
    #1;
    e = vec(1, 1, 1, 0, 8'd0, 2'd0);
    chk++; if (obs !== e) begin fails++; $display("FAIL midrst_run_async: got %h want %h", obs, e); end
    apply_reset(1'b1);
    tick(7);                           // STABLE since edge 5
    e = vec(0, 1, 1, 0, 8'd0, 2'd2);
    chk++; if (obs !== e) begin fails++; $display("FAIL midrst_stable: got %h want %h", obs, e); end
    #2 rst = 1'b1;
    #1;
    e = vec(1, 1, 1, 0, 8'd0, 2'd0);
    chk++; if (obs !== e) begin fails++; $display("FAIL midrst_stable_async: got %h want %h", obs, e); end
    apply_reset(1'b0);
    tick(3);
    e = vec(1, 1, 1, 0, 8'd0, 2'd0);
    chk++; if (obs !== e) begin fails++; $display("FAIL midrst_restart: got %h want %h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_unstable();
    test_lock_loss();
    test_timeout();
    test_set_wins();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end

endmodule
